// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared constants and helpers for the binary neural network datapath.
//   BNN_DW         : width of signed convolution results
//   BNN_W0/BNN_W1  : feature-map side lengths for layer-1 / layer-2 mode
//   POOL_N0/N1     : number of pooled results per map in each mode
//   smax()         : signed maximum of two convolution results
// ---------------------------------------------------------------------------
package bnn_pkg;

    localparam int BNN_DW  = 32;
    localparam int BNN_W0  = 24;
    localparam int BNN_W1  = 8;
    localparam int POOL_N0 = (BNN_W0 / 2) * (BNN_W0 / 2);
    localparam int POOL_N1 = (BNN_W1 / 2) * (BNN_W1 / 2);

    // Both operands are declared signed, so the comparison is a true
    // two's-complement compare and the most negative value cannot overflow.
    function automatic logic signed [BNN_DW-1:0] smax(
        input logic signed [BNN_DW-1:0] a,
        input logic signed [BNN_DW-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// ---------------------------------------------------------------------------
// pool_linebuf
// Register-file line buffer that carries the horizontal pair maxima of an
// even row forward to the following odd row of the pooling window.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset (clears all entries)
//   we        : write enable
//   waddr     : write entry (col>>1)
//   wdata     : signed data to store
//   raddr     : read entry (col>>1)
//   rdata     : asynchronous read data
// ---------------------------------------------------------------------------
module pool_linebuf
    import bnn_pkg::*;
#(
    parameter int DEPTH = BNN_W0 / 2,
    parameter int DW    = BNN_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem_q [DEPTH];

    // Single write port; every entry is cleared on reset so a map that
    // starts after reset never sees stale maxima.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read is combinational so the odd-row beat can compare against the
    // stored pair maximum in the same cycle it arrives.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pool_bin.sv
// ---------------------------------------------------------------------------
// pool_bin
// 2x2 stride-2 max pooling followed by binarisation of a row-major stream of
// signed convolution results (W0xW0 in mode 0, W1xW1 in mode 1).
// Ports:
//   clk, rstn : clock and asynchronous active-low reset
//   state     : layer mode, sampled on the first beat of each map
//   ivalid    : input beat valid (no backpressure)
//   idone     : marks the final beat of a map, together with ivalid
//   din       : signed convolution result
//   thresh    : signed threshold, present only with POOL_BIN_THRESH_EN
//   ovalid    : one-cycle pulse per pooled result
//   dout      : binarised pooled maximum
//   oidx      : raster index of the pooled result
//   odone     : pulses with the final result of a map
//   err       : sticky framing error (misplaced or missing idone)
// Optional feature macro: POOL_BIN_THRESH_EN
//   defined   : dout = (max >= thresh), thresh latched on the first beat
//   undefined : dout = (max >= 0), taken from the sign bit
// ---------------------------------------------------------------------------
module pool_bin
    import bnn_pkg::*;
#(
    parameter int DW   = BNN_DW,
    parameter int W0   = BNN_W0,
    parameter int W1   = BNN_W1,
    parameter int IDXW = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 state,
    input  logic                 ivalid,
    input  logic                 idone,
    input  logic signed [DW-1:0] din,
`ifdef POOL_BIN_THRESH_EN
    input  logic signed [DW-1:0] thresh,
`endif
    output logic                 ovalid,
    output logic                 dout,
    output logic [IDXW-1:0]      oidx,
    output logic                 odone,
    output logic                 err
);

    localparam int CW = $clog2(W0);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] LAST0 = CW'(W0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(W1 - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [CW-1:0]        row_q, row_d;
    logic                 mode_q, mode_d;
    logic signed [DW-1:0] hold_q, hold_d;
    logic [IDXW-1:0]      cnt_q, cnt_d;
    logic                 ovalid_q, ovalid_d;
    logic                 dout_q, dout_d;
    logic [IDXW-1:0]      oidx_q, oidx_d;
    logic                 odone_q, odone_d;
    logic                 err_q, err_d;

    logic                 firstBeat;
    logic                 modeEff;
    logic [CW-1:0]        lastPos;
    logic                 atLast;
    logic                 earlyDone;
    logic                 accept;
    logic                 lbWe;
    logic                 winDone;
    logic                 winBit;
    logic [AW-1:0]        lbAddr;
    logic signed [DW-1:0] lbRdata;
    logic signed [DW-1:0] winMax;
    logic signed [DW-1:0] colMax;

`ifdef POOL_BIN_THRESH_EN
    logic signed [DW-1:0] thresh_q, thresh_d;
`endif

    pool_linebuf #(
        .DEPTH (W0 / 2),
        .DW    (DW),
        .AW    (AW)
    ) u_linebuf (
        .clk   (clk),
        .rstn  (rstn),
        .we    (lbWe),
        .waddr (lbAddr),
        .wdata (winMax),
        .raddr (lbAddr),
        .rdata (lbRdata)
    );

    // Position decode. On the first beat of a map the mode register has not
    // been loaded yet, so the live state input decides the map size for that
    // beat. A beat carrying idone anywhere except the last position aborts
    // the map and is not allowed to touch the pooling datapath.
    always_comb begin
        firstBeat = (row_q == '0) && (col_q == '0);
        modeEff   = firstBeat ? state : mode_q;
        lastPos   = modeEff ? LAST1 : LAST0;
        atLast    = (row_q == lastPos) && (col_q == lastPos);
        earlyDone = ivalid && idone && !atLast;
        accept    = ivalid && !earlyDone;
        lbAddr    = col_q[CW-1:1];
        winMax    = smax(hold_q, din);
        colMax    = smax(lbRdata, din);
        lbWe      = accept && !row_q[0] && col_q[0];
        winDone   = accept && row_q[0] && col_q[0];
    end

    // Binarisation of the completed window maximum. Without the threshold
    // option zero counts as positive, which is exactly the inverted sign bit.
    always_comb begin
`ifdef POOL_BIN_THRESH_EN
        winBit = (winMax >= thresh_q);
`else
        winBit = ~winMax[DW-1];
`endif
    end

    // Next-state logic. Even-row beats build horizontal pair maxima (first
    // in hold, then in the line buffer); odd-row beats fold in the stored
    // pair and the window closes on the odd column. The last position and an
    // aborted map both return counters and the pooled index to frame start.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        mode_d   = mode_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        ovalid_d = winDone;
        dout_d   = dout_q;
        oidx_d   = oidx_q;
        odone_d  = winDone && atLast;
        err_d    = err_q | earlyDone | (ivalid && atLast && !idone);
`ifdef POOL_BIN_THRESH_EN
        thresh_d = thresh_q;
`endif

        if (ivalid && firstBeat) begin
            mode_d = state;
`ifdef POOL_BIN_THRESH_EN
            thresh_d = thresh;
`endif
        end

        if (ivalid) begin
            if (earlyDone || atLast) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == lastPos) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (accept && !col_q[0]) begin
            hold_d = row_q[0] ? colMax : din;
        end

        if (winDone) begin
            dout_d = winBit;
            oidx_d = cnt_q;
            cnt_d  = atLast ? '0 : cnt_q + 1'b1;
        end else if (earlyDone) begin
            cnt_d = '0;
        end
    end

    // State registers; everything, including the sticky error flag, is
    // cleared asynchronously so the next beat after reset is position (0,0).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= '0;
            ovalid_q <= 1'b0;
            dout_q   <= 1'b0;
            oidx_q   <= '0;
            odone_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef POOL_BIN_THRESH_EN
            thresh_q <= '0;
`endif
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            dout_q   <= dout_d;
            oidx_q   <= oidx_d;
            odone_q  <= odone_d;
            err_q    <= err_d;
`ifdef POOL_BIN_THRESH_EN
            thresh_q <= thresh_d;
`endif
        end
    end

    assign ovalid = ovalid_q;
    assign dout   = dout_q;
    assign oidx   = oidx_q;
    assign odone  = odone_q;
    assign err    = err_q;

endmodule

// File: tb/tb_pool_bin.sv
// ---------------------------------------------------------------------------
// tb_pool_bin
// Self-checking bench for pool_bin. Each map is held as a plain pixel array;
// the expected pooled results are computed from that array by taking the
// maximum of each 2x2 block and binarising it, then checked cycle by cycle.
// Define POOL_BIN_THRESH_EN for both bench and design to test the threshold.
// ---------------------------------------------------------------------------
module tb_pool_bin;

    localparam int DW = 32;

    typedef struct {
        int due;
        bit d;
        int idx;
        bit done;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          state  = 1'b0;
    logic          ivalid = 1'b0;
    logic          idone  = 1'b0;
    logic [DW-1:0] din    = '0;
`ifdef POOL_BIN_THRESH_EN
    logic [DW-1:0] thresh = '0;
`endif
    logic          ovalid;
    logic          dout;
    logic [7:0]    oidx;
    logic          odone;
    logic          err;

    exp_t              expQ[$];
    int                cyc         = 0;
    int                tests       = 0;
    int                fails       = 0;
    int                outCount    = 0;
    int                lastDoneIdx = -1;
    int                threshVal   = 0;
    bit                gotDout [0:143];
    logic signed [31:0] pix    [0:575];

    pool_bin dut (
        .clk    (clk),
        .rstn   (rstn),
        .state  (state),
        .ivalid (ivalid),
        .idone  (idone),
        .din    (din),
`ifdef POOL_BIN_THRESH_EN
        .thresh (thresh),
`endif
        .ovalid (ovalid),
        .dout   (dout),
        .oidx   (oidx),
        .odone  (odone),
        .err    (err)
    );

    // Free-running clock and a posedge count used to time expected outputs.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the run ever wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit binOf(input logic signed [31:0] m);
`ifdef POOL_BIN_THRESH_EN
        return m >= $signed(threshVal);
`else
        return m >= 0;
`endif
    endfunction

    // Maximum of the 2x2 block (i,j) of a w x w map in the pixel array.
    function automatic logic signed [31:0] windowMax(input int w, input int i, input int j);
        logic signed [31:0] best;
        best = pix[2 * i * w + 2 * j];
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                if (pix[(2 * i + dr) * w + 2 * j + dc] > best) begin
                    best = pix[(2 * i + dr) * w + 2 * j + dc];
                end
            end
        end
        return best;
    endfunction

    task automatic buildRamp();
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 24; c++) begin
                pix[r * 24 + c] = r * 24 + c - 300;
            end
        end
    endtask

    task automatic buildAlt();
        for (int k = 0; k < 64; k++) begin
            pix[k] = ((k % 8) % 2 == 0) ? 32'sd5 : -32'sd7;
        end
    endtask

    task automatic buildBoundary();
        for (int k = 0; k < 64; k++) begin
            pix[k] = -32'sd1;
        end
        pix[2 * 8 + 4] = 32'sd0;
        pix[3 * 8 + 5] = 32'sh80000000;
    endtask

    task automatic buildRandom();
        for (int k = 0; k < 576; k++) begin
            pix[k] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ivalid = 1'b0;
            idone  = 1'b0;
        end
    endtask

    // Drive beats 0..lastBeat of a map, idone on lastBeat when giveDone.
    // Random gap cycles carry junk data, random state and stray idone, all of
    // which must be ignored. Each completed 2x2 block queues its expectation.
    task automatic applyStimulus(input bit m, input int gapPct, input int lastBeat, input bit giveDone);
        int w;
        int n;
        int r;
        int c;
        exp_t e;
        w = m ? 8 : 24;
        n = w * w;
        for (int k = 0; k <= lastBeat; k++) begin
            while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
                @(negedge clk);
                ivalid = 1'b0;
                idone  = 1'($urandom_range(1));
                state  = 1'($urandom_range(1));
                din    = $urandom;
            end
            @(negedge clk);
            r      = k / w;
            c      = k % w;
            ivalid = 1'b1;
            din    = pix[k];
            idone  = (k == lastBeat) && giveDone;
            state  = (k == 0) ? m : 1'($urandom_range(1));
`ifdef POOL_BIN_THRESH_EN
            thresh = (k == 0) ? threshVal : $urandom;
`endif
            if ((r % 2 == 1) && (c % 2 == 1) && !(idone && k != n - 1)) begin
                e.due  = cyc + 1;
                e.d    = binOf(windowMax(w, r / 2, c / 2));
                e.idx  = (r / 2) * (w / 2) + c / 2;
                e.done = (k == n - 1);
                expQ.push_back(e);
            end
        end
    endtask

    // Compare process: every cycle the outputs either match the queued
    // result due now, or must be idle. During reset everything must be zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                checkOutput("rst_ovalid", 32'(ovalid), 0);
                checkOutput("rst_dout", 32'(dout), 0);
                checkOutput("rst_oidx", 32'(oidx), 0);
                checkOutput("rst_odone", 32'(odone), 0);
                checkOutput("rst_err", 32'(err), 0);
            end else if (expQ.size() > 0 && expQ[0].due == cyc) begin
                e = expQ.pop_front();
                checkOutput("ovalid", 32'(ovalid), 1);
                checkOutput("dout", 32'(dout), 32'(e.d));
                checkOutput("oidx", 32'(oidx), e.idx);
                checkOutput("odone", 32'(odone), 32'(e.done));
                if (ovalid) begin
                    outCount++;
                    if (oidx < 144) gotDout[oidx] = dout;
                    if (odone) lastDoneIdx = int'(oidx);
                end
            end else begin
                checkOutput("ovalid_idle", 32'(ovalid), 0);
                checkOutput("odone_idle", 32'(odone), 0);
                if (expQ.size() > 0 && expQ[0].due < cyc) begin
                    checkOutput("late_output", 0, 1);
                    void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic startMap();
        outCount    = 0;
        lastDoneIdx = -1;
    endtask

    initial begin
`ifdef POOL_BIN_THRESH_EN
        threshVal = 10;
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("after_reset_err", 32'(err), 0);

        $display("[TB] mode 0 ramp");
        buildRamp();
        startMap();
        applyStimulus(1'b0, 0, 575, 1'b1);
        idle(3);
        checkOutput("ramp_count", outCount, 144);
        checkOutput("ramp_odone_idx", lastDoneIdx, 143);
        checkOutput("ramp_dout0", 32'(gotDout[0]), 0);
        checkOutput("ramp_dout71", 32'(gotDout[71]), 0);
        checkOutput("ramp_dout72", 32'(gotDout[72]), 1);
        checkOutput("ramp_dout143", 32'(gotDout[143]), 1);
        checkOutput("ramp_err", 32'(err), 0);
        checkOutput("ramp_drain", expQ.size(), 0);

        $display("[TB] mode 1 alternating");
        buildAlt();
        startMap();
        applyStimulus(1'b1, 0, 63, 1'b1);
        idle(3);
        checkOutput("alt_count", outCount, 16);
        checkOutput("alt_odone_idx", lastDoneIdx, 15);
        checkOutput("alt_dout15", 32'(gotDout[15]), 1);

        $display("[TB] negative/zero boundary");
        buildBoundary();
        startMap();
        applyStimulus(1'b1, 0, 63, 1'b1);
        idle(3);
        checkOutput("bnd_count", outCount, 16);
        checkOutput("bnd_dout6", 32'(gotDout[6]), 1);
        checkOutput("bnd_dout5", 32'(gotDout[5]), 0);
        checkOutput("bnd_dout7", 32'(gotDout[7]), 0);

        $display("[TB] gaps then back-to-back map");
        buildRamp();
        startMap();
        applyStimulus(1'b0, 30, 575, 1'b1);
        buildAlt();
        applyStimulus(1'b1, 0, 63, 1'b1);
        idle(3);
        checkOutput("b2b_count", outCount, 160);
        checkOutput("b2b_odone_idx", lastDoneIdx, 15);
        checkOutput("b2b_dout72", 32'(gotDout[72]), 1);
        checkOutput("b2b_err", 32'(err), 0);

        $display("[TB] random maps");
        for (int t = 0; t < 4; t++) begin
            bit m;
            m = 1'($urandom_range(1));
            buildRandom();
            startMap();
            applyStimulus(m, 15, m ? 63 : 575, 1'b1);
            idle(2);
            checkOutput("rand_count", outCount, m ? 16 : 144);
        end
        checkOutput("rand_err", 32'(err), 0);

        $display("[TB] last beat without idone");
        buildRandom();
        startMap();
        applyStimulus(1'b1, 0, 63, 1'b0);
        idle(2);
        checkOutput("nodone_count", outCount, 16);
        checkOutput("nodone_odone_idx", lastDoneIdx, 15);
        checkOutput("nodone_err", 32'(err), 1);

        $display("[TB] reset mid-map");
        buildRamp();
        applyStimulus(1'b0, 0, 299, 1'b0);
        @(negedge clk);
        ivalid = 1'b0;
        rstn   = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        startMap();
        applyStimulus(1'b0, 0, 575, 1'b1);
        idle(3);
        checkOutput("rstmid_count", outCount, 144);
        checkOutput("rstmid_err", 32'(err), 0);

        $display("[TB] early idone");
        buildRamp();
        applyStimulus(1'b0, 0, 100, 1'b1);
        idle(2);
        checkOutput("early_err", 32'(err), 1);
        checkOutput("early_drain", expQ.size(), 0);
        startMap();
        applyStimulus(1'b0, 0, 575, 1'b1);
        idle(3);
        checkOutput("early_next_count", outCount, 144);
        checkOutput("early_next_odone_idx", lastDoneIdx, 143);
        checkOutput("early_err_held", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
